sigma_delta_i2s_tx: RTL
=======================

Name: sigma_delta_i2s_tx

Overview:
Serialises decimated sigma-delta ADC samples onto a standard I2S (Philips) bus for an external codec or DSP. Sits directly downstream of the ADC decimator and takes its output word and one-cycle valid strobe. The block generates BCLK and LRCLK from the system clock by integer division, and holds one pending sample between frames. It flags overrun (a sample is overwritten) and underrun (no new sample at frame start).

Parameters:
SAMPLE_BITLEN, 16, width of the input sample. Sent MSB-first, two's complement passed through unchanged.
SLOT_BITLEN, 32, BCLK periods per channel slot. Must be >= SAMPLE_BITLEN. Unused LSB positions are driven 0.
BCLK_DIV, 4, clk cycles per BCLK period. Must be even and >= 2.

Ports:
clk  in  1  system clock, same clock as the ADC decimator
rst_n  in  1  asynchronous active-low reset
sample_in  in  SAMPLE_BITLEN  sample word from the decimator
sample_valid  in  1  one-cycle strobe; sample_in is valid in that cycle
i2s_bclk  out  1  bit clock
i2s_lrclk  out  1  word select; 0 = left, 1 = right
i2s_sdata  out  1  serial data; changes on the BCLK falling edge
frame_start  out  1  one-clk pulse when a new frame is loaded
overrun  out  1  one-clk pulse when the pending sample is overwritten
underrun  out  1  one-clk pulse when a frame starts with no pending sample

Behaviour:
- Reset is asynchronous and active-low. While rst_n is 0:
  - all outputs are 0;
  - div_cnt = 0 and bit_cnt = 2*SLOT_BITLEN-1;
  - the pending register is empty and the frame register is 0.
- Divider: div_cnt counts 0..BCLK_DIV-1 and wraps.
  - i2s_bclk is a registered output, 1 when the next div_cnt >= BCLK_DIV/2.
  - "fall" event: div_cnt == BCLK_DIV-1. This is a single-cycle internal tick.
- Bit counter: on each fall, bit_cnt increments modulo 2*SLOT_BITLEN.
  - bit_cnt 0..SLOT-1 is the left slot; SLOT..2*SLOT-1 is the right slot.
  - Slot bit s = bit_cnt mod SLOT_BITLEN.
- All I2S outputs are registered and update in the same clk as the fall tick, so they coincide with the BCLK falling edge.
  - i2s_lrclk = 1 when bit_cnt(new) is in [SLOT-1, 2*SLOT-2], else 0. LRCLK therefore leads the channel's MSB by one BCLK, as I2S requires.
  - i2s_sdata = frame[SAMPLE_BITLEN-1-s] when s < SAMPLE_BITLEN, else 0.
  - Mono source: the left and right slots carry the same frame word.
- Frame load happens on the fall where bit_cnt wraps to 0:
  - If pending is full: frame <= pending, and pending becomes empty.
  - If pending is empty: frame is unchanged (the last sample repeats) and underrun pulses.
  - frame_start pulses in the same cycle in both cases.
- Sample capture on sample_valid:
  - pending <= sample_in and pending becomes full.
  - If pending was already full and this is not a frame-load cycle, overrun pulses and the newer sample wins.
- Simultaneous sample_valid and frame load:
  - The load takes the old pending content, or underruns if pending was empty.
  - The new sample becomes pending.
  - overrun does not pulse.
- Latency: a sample captured before a frame-load tick appears as the left MSB on i2s_sdata in that same load cycle. Otherwise it appears at the next load, at most 2*SLOT_BITLEN*BCLK_DIV clk later.
- Frame period: 2*SLOT_BITLEN*BCLK_DIV clk (256 clk at defaults).
- Reset asserted mid-frame: all outputs go to 0 immediately and the pending sample is discarded. After release, the first load occurs BCLK_DIV clk later and underruns unless a sample has arrived.
- No handshake back-pressure: the decimator free-runs and loss is reported only through overrun.

Test Plan (defaults SAMPLE_BITLEN=16, SLOT_BITLEN=32, BCLK_DIV=4):
1. Release rst_n with no samples -> outputs 0 during reset; frame_start and underrun pulse together at the 4th clk after release; i2s_sdata stays 0; i2s_bclk has a period of 4 clk at 50% duty.
2. sample_in=16'hA5C3 valid 2 clk after release -> at the first frame_start, sdata over 32 BCLKs carries 1010010111000011 then 16 zeros; the right slot is identical; no underrun.
3. Free-run 3 frames -> lrclk rises at left bit 31 and falls at right bit 31; lrclk period is 256 clk; frame_start pulses every 256 clk.
4. Two valids (16'h1234, then 16'h8001) 10 clk apart mid-frame -> overrun pulses on the second valid; the next frame transmits 16'h8001.
5. No valid for one whole frame after sending 16'h7FFF -> underrun pulses at frame_start; 16'h7FFF is retransmitted in both slots.
6. Valid coincident with a frame-load tick while pending holds 16'h0F0F, new sample 16'hF0F0 -> frame sends 16'h0F0F, no overrun; the next frame sends 16'hF0F0.
7. Drop rst_n at bit_cnt=20 -> outputs 0 asynchronously; after release, the first load underruns with frame=0.

Source files
------------

// File: rtl/sigma_delta_i2s_tx_if.sv
// Sample input and I2S/status output bundle for sigma_delta_i2s_tx.
// slave is the serialiser side, master is the decimator/observer side.
interface sigma_delta_i2s_tx_if #(
  parameter int SAMPLE_BITLEN = 16
) ();
  logic [SAMPLE_BITLEN-1:0] sample_in;
  logic                     sample_valid;
  logic                     i2s_bclk;
  logic                     i2s_lrclk;
  logic                     i2s_sdata;
  logic                     frame_start;
  logic                     overrun;
  logic                     underrun;

  modport slave (
    input  sample_in, sample_valid,
    output i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, overrun, underrun
  );

  modport master (
    output sample_in, sample_valid,
    input  i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, overrun, underrun
  );
endinterface

// File: rtl/sigma_delta_i2s_tx.sv
// Decimated sample to I2S serialiser; one pending sample, mono copied to both slots.
// Sample shows as left MSB at the next frame load; no back-pressure, losses flagged via overrun/underrun.
module sigma_delta_i2s_tx #(
  parameter int SAMPLE_BITLEN = 16,
  parameter int SLOT_BITLEN   = 32,
  parameter int BCLK_DIV      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sigma_delta_i2s_tx_if.slave   bus
);
  localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_BITLEN);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITLEN - 1);
  localparam logic [BW-1:0] SLOT_W   = BW'(SLOT_BITLEN);
  localparam logic [BW-1:0] LR_LO    = BW'(SLOT_BITLEN - 1);
  localparam logic [BW-1:0] LR_HI    = BW'(2 * SLOT_BITLEN - 2);
  localparam logic [BW-1:0] SAMP_W   = BW'(SAMPLE_BITLEN);

  logic [DW-1:0]            div_cnt;
  logic [BW-1:0]            bit_cnt;
  logic [SAMPLE_BITLEN-1:0] pending;
  logic                     pend_full;
  logic [SAMPLE_BITLEN-1:0] frame;

  logic bclk_q, lrclk_q, sdata_q, frame_start_q, overrun_q, underrun_q;

  logic                     fall;
  logic                     load;
  logic [DW-1:0]            div_nxt;
  logic [BW-1:0]            bit_nxt;
  logic [BW-1:0]            slot_bit;
  logic [SAMPLE_BITLEN-1:0] frame_nxt;
  logic [SAMPLE_BITLEN-1:0] frame_shift;
  logic                     lr_nxt;
  logic                     sd_nxt;

  always_comb begin
    fall        = (div_cnt == DIV_LAST);
    div_nxt     = fall ? '0 : div_cnt + 1'b1;
    load        = fall && (bit_cnt == BIT_LAST);
    bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    slot_bit    = (bit_nxt >= SLOT_W) ? bit_nxt - SLOT_W : bit_nxt;
    // Outputs on a load tick already reflect the freshly loaded word.
    frame_nxt   = (load && pend_full) ? pending : frame;
    frame_shift = frame_nxt << slot_bit;
    sd_nxt      = (slot_bit < SAMP_W) && frame_shift[SAMPLE_BITLEN-1];
    // Word select flips one BCLK ahead of each slot's MSB.
    lr_nxt      = (bit_nxt >= LR_LO) && (bit_nxt <= LR_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt       <= '0;
      bit_cnt       <= BIT_LAST;
      pending       <= '0;
      pend_full     <= 1'b0;
      frame         <= '0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      underrun_q    <= 1'b0;

      div_cnt <= div_nxt;
      bclk_q  <= (div_nxt >= DIV_HALF);

      if (fall) begin
        bit_cnt <= bit_nxt;
        lrclk_q <= lr_nxt;
        sdata_q <= sd_nxt;
      end

      if (load) begin
        frame_start_q <= 1'b1;
        frame         <= frame_nxt;
        underrun_q    <= !pend_full;
      end

      // A coincident load consumes the old word, so the new one is not an overrun.
      if (bus.sample_valid) begin
        pending   <= bus.sample_in;
        pend_full <= 1'b1;
        overrun_q <= pend_full && !load;
      end else if (load) begin
        pend_full <= 1'b0;
      end
    end
  end

  assign bus.i2s_bclk    = bclk_q;
  assign bus.i2s_lrclk   = lrclk_q;
  assign bus.i2s_sdata   = sdata_q;
  assign bus.frame_start = frame_start_q;
  assign bus.overrun     = overrun_q;
  assign bus.underrun    = underrun_q;
endmodule
